// File: rtl/vote_hex_display.sv
// Majority-vote display stage: collects per-frame class decisions,
// votes over VOTE_N frames and drives three 7-segment digits.
module vote_hex_display #(
  parameter int NUM_CLASSES    = 2,
  parameter int CLASS_W        = 3,
  parameter int VOTE_N         = 4,
  parameter int SWAP_BIN       = 1,
  parameter int BLINK_DIV      = 25000000,
  parameter int HEX_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               lock_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic               valid_out,
  output logic               locked,
  output logic               err
);

  localparam int CW = $clog2(VOTE_N + 1);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam logic [CW-1:0] LAST_FRAME = CW'(VOTE_N - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam bit BIN_SWAP = (SWAP_BIN == 1) && (NUM_CLASSES == 2);

  typedef enum logic [1:0] {
    COLLECT,
    DECIDE,
    HOLD
  } state_t;

  // Active-low gfedcba pattern of one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_BLANK;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   frame_q, frame_d;
  logic [CW-1:0]   vote_q [NUM_CLASSES];
  logic [CW-1:0]   vote_d [NUM_CLASSES];
  logic            bad_q, bad_d;
  logic [6:0]      hex0_q, hex0_d;
  logic [6:0]      hex1_q, hex1_d;
  logic [6:0]      hex2_q, hex2_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;

  logic            xfer;
  logic            cls_ok;
  logic [2:0]      win_idx;
  logic [CW-1:0]   win_cnt;
  logic [3:0]      win_digit;
  logic [6:0]      hex0_raw;

  assign in_ready = (state_q == COLLECT) && !clear;
  assign xfer     = in_valid && in_ready;
  assign cls_ok   = int'(in_class) < NUM_CLASSES;

  // Highest vote wins; strict compare keeps the lowest index on ties.
  always_comb begin
    win_idx = 3'd0;
    win_cnt = vote_q[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (vote_q[i] > win_cnt) begin
        win_idx = 3'(i);
        win_cnt = vote_q[i];
      end
    end
  end

  assign win_digit = BIN_SWAP ? {3'b000, ~win_idx[0]}
                              : {1'b0, win_idx};

  // Vote FSM, counters and registered display contents.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    vote_d  = vote_q;
    bad_d   = bad_q;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    hex2_d  = hex2_q;
    valid_d = valid_q;
    err_d   = err_q;

    unique case (state_q)
      COLLECT: begin
        if (xfer) begin
          frame_d = frame_q + 1'b1;
          if (cls_ok) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              if (in_class == CLASS_W'(i)) begin
                vote_d[i] = vote_q[i] + 1'b1;
              end
            end
          end else begin
            bad_d = 1'b1;
          end
          if (frame_q == LAST_FRAME) begin
            state_d = DECIDE;
          end
        end
      end
      DECIDE: begin
        hex0_d  = bad_q ? SEG_E : seg7(win_digit);
        hex1_d  = seg7(4'(win_cnt));
        hex2_d  = seg7(4'(frame_q));
        valid_d = 1'b1;
        err_d   = bad_q;
        frame_d = '0;
        bad_d   = 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
          vote_d[i] = '0;
        end
        state_d = lock_en ? HOLD : COLLECT;
      end
      HOLD: begin
        state_d = HOLD;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    if (clear) begin
      state_d = COLLECT;
      frame_d = '0;
      bad_d   = 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        vote_d[i] = '0;
      end
      hex0_d  = SEG_BLANK;
      hex1_d  = SEG_BLANK;
      hex2_d  = SEG_BLANK;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Blink timer idles at 0/on while no error, so it restarts on err rising.
  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    if (!err_q) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + 1'b1;
    end
  end

  // State, counter and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      frame_q <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        vote_q[i] <= '0;
      end
      bad_q   <= 1'b0;
      hex0_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      blink_q <= '0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      vote_q  <= vote_d;
      bad_q   <= bad_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  assign hex0_raw = (err_q && !phase_q) ? SEG_BLANK : hex0_q;

  assign hex0 = (HEX_ACTIVE_LOW != 0) ? hex0_raw : ~hex0_raw;
  assign hex1 = (HEX_ACTIVE_LOW != 0) ? hex1_q : ~hex1_q;
  assign hex2 = (HEX_ACTIVE_LOW != 0) ? hex2_q : ~hex2_q;

  assign valid_out = valid_q;
  assign locked    = (state_q == HOLD);
  assign err       = err_q;

endmodule

// File: tb/tb_vote_hex_display.sv
// Directed bench for vote_hex_display: voting, ties, lock/hold,
// error blink, clear drop and mid-collect reset.
module tb_vote_hex_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       lock_en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_class;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic       valid_out;
  logic       locked;
  logic       err;

  int n_chk;
  int n_err;

  vote_hex_display #(
    .NUM_CLASSES   (2),
    .CLASS_W       (3),
    .VOTE_N        (4),
    .SWAP_BIN      (1),
    .BLINK_DIV     (4),
    .HEX_ACTIVE_LOW(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .lock_en  (lock_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_class (in_class),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .valid_out(valid_out),
    .locked   (locked),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    in_class = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [2:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    lock_en  = 1'b0;
    in_valid = 1'b0;
    in_class = 3'd0;

    @(negedge clk);
    check("rst_hex0", 32'(hex0), 32'(SB));
    check("rst_hex1", 32'(hex1), 32'(SB));
    check("rst_hex2", 32'(hex2), 32'(SB));
    check("rst_valid", 32'(valid_out), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 1);

    // majority 1,1,0,1 -> class 1 shown as '0', 3 votes, 4 frames
    send4(3'd1, 3'd1, 3'd0, 3'd1);
    @(negedge clk);
    check("maj_lat_valid", 32'(valid_out), 0);
    check("maj_decide_ready", 32'(in_ready), 0);
    @(negedge clk);
    check("maj_valid", 32'(valid_out), 1);
    check("maj_hex0", 32'(hex0), 32'(S0));
    check("maj_hex1", 32'(hex1), 32'(S3));
    check("maj_hex2", 32'(hex2), 32'(S4));
    check("maj_err", 32'(err), 0);
    check("maj_locked", 32'(locked), 0);
    check("maj_ready", 32'(in_ready), 1);

    // tie 0,1,0,1 -> class 0 shown as '1', 2 votes
    send(3'd0);
    send(3'd1);
    @(negedge clk);
    check("tie_keep_hex0", 32'(hex0), 32'(S0));
    check("tie_keep_valid", 32'(valid_out), 1);
    send(3'd0);
    send(3'd1);
    @(negedge clk);
    @(negedge clk);
    check("tie_hex0", 32'(hex0), 32'(S1));
    check("tie_hex1", 32'(hex1), 32'(S2));
    check("tie_hex2", 32'(hex2), 32'(S4));

    // lock mode: decision freezes, further frames ignored
    lock_en = 1'b1;
    send4(3'd1, 3'd1, 3'd1, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check("lock_locked", 32'(locked), 1);
    check("lock_hex0", 32'(hex0), 32'(S0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_class = 3'(i % 2);
      lock_en  = (i < 4);
      #1;
      check("hold_ready", 32'(in_ready), 0);
      check("hold_locked", 32'(locked), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_hex0", 32'(hex0), 32'(S0));
    check("hold_hex1", 32'(hex1), 32'(S3));
    check("hold_hex2", 32'(hex2), 32'(S4));
    check("hold_valid", 32'(valid_out), 1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_class = 3'd0;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_hex0", 32'(hex0), 32'(SB));
    check("clr_hex1", 32'(hex1), 32'(SB));
    check("clr_hex2", 32'(hex2), 32'(SB));
    check("clr_valid", 32'(valid_out), 0);
    check("clr_locked", 32'(locked), 0);
    check("clr_ready", 32'(in_ready), 1);

    // illegal class 5 -> 'E' blinking every 4 cycles
    lock_en = 1'b0;
    send4(3'd0, 3'd5, 3'd0, 3'd0);
    @(negedge clk);
    check("err_lat", 32'(err), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("blink_hex0", 32'(hex0),
            32'((((k / 4) % 2) == 0) ? SE : SB));
      check("blink_hex1", 32'(hex1), 32'(S3));
      check("blink_hex2", 32'(hex2), 32'(S4));
      check("blink_err", 32'(err), 1);
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("errclr_err", 32'(err), 0);
    check("errclr_hex0", 32'(hex0), 32'(SB));

    // clear on the 3rd frame drops it and discards the partial vote
    send(3'd0);
    send(3'd0);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_class = 3'd0;
    #1;
    check("drop_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    send(3'd1);
    send(3'd1);
    send(3'd1);
    @(negedge clk);
    @(negedge clk);
    check("drop_novalid", 32'(valid_out), 0);
    send(3'd1);
    @(negedge clk);
    @(negedge clk);
    check("drop_valid", 32'(valid_out), 1);
    check("drop_hex0", 32'(hex0), 32'(S0));
    check("drop_hex1", 32'(hex1), 32'(S4));

    // async reset after 2 frames discards the partial vote
    send(3'd0);
    send(3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_hex0", 32'(hex0), 32'(SB));
    check("arst_hex1", 32'(hex1), 32'(SB));
    check("arst_valid", 32'(valid_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", 32'(in_ready), 1);
    send(3'd0);
    send(3'd0);
    send(3'd0);
    @(negedge clk);
    @(negedge clk);
    check("arst_novalid", 32'(valid_out), 0);
    send(3'd0);
    @(negedge clk);
    @(negedge clk);
    check("arst_dec_valid", 32'(valid_out), 1);
    check("arst_dec_hex0", 32'(hex0), 32'(S1));
    check("arst_dec_hex1", 32'(hex1), 32'(S4));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
